// File: rtl/fifo_vr_drain_pkg.sv
// -----------------------------------------------------------------------------
// fifo_vr_drain_pkg
// Shared constants, types and helpers for the FIFO-to-valid/ready drain block
// and its 3-entry output skid buffer.
//   SKID_DEPTH : number of words the output skid buffer can hold
//   skid_cnt_t : occupancy / pointer type of the skid buffer
//   ptr_inc    : advances a skid pointer, wrapping 2 -> 0
// -----------------------------------------------------------------------------
package fifo_vr_drain_pkg;

    localparam int unsigned SKID_DEPTH = 3;

    typedef logic [1:0] skid_cnt_t;

    function automatic skid_cnt_t ptr_inc(input skid_cnt_t p);
        return (p == skid_cnt_t'(SKID_DEPTH - 1)) ? 2'd0 : (p + 2'd1);
    endfunction

endpackage

// File: rtl/fifo_vr_drain_if.sv
// -----------------------------------------------------------------------------
// Interfaces used by fifo_vr_drain.
//   common_sync_fifo_if : access to a synchronous FIFO. Bundle m is driven by the
//                         master (read/write/clr/wdata), bundle s by the FIFO
//                         (nempty/level/rdata, rdata registered with latency 1).
//   vr_if               : valid/ready stream; NV valid bits, NR ready bits and
//                         ND data lanes of type DTYPE.
// -----------------------------------------------------------------------------
interface common_sync_fifo_if #(
    parameter int DW  = 32,
    parameter int DL  = 2,
    parameter int DWO = 1
);
    typedef struct packed {
        logic          read;
        logic          write;
        logic          clr;
        logic [DW-1:0] wdata;
    } m_t;

    typedef struct packed {
        logic              nempty;
        logic [DL:0]       level;
        logic [DW*DWO-1:0] rdata;
    } s_t;

    m_t m;
    s_t s;

    modport master (output m, input  s);
    modport slave  (input  m, output s);
endinterface

interface vr_if #(
    parameter int  NV    = 1,
    parameter int  NR    = 1,
    parameter int  ND    = 1,
    parameter type DTYPE = logic
);
    logic [NV-1:0] valid;
    logic [NR-1:0] ready;
    DTYPE          data [ND];

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/fifo_vr_skid3.sv
// -----------------------------------------------------------------------------
// fifo_vr_skid3
// Three-entry circular skid buffer. Head data and valid come straight from
// registers; the storage itself is not reset.
//   clk       : clock
//   srst      : synchronous clear of pointers and count (reset or flush)
//   push      : write push_data at the tail
//   push_data : incoming word
//   pop       : drop the head word
//   head_data : word at the head
//   valid     : buffer holds at least one word
//   count     : occupancy 0..3
// fifo_vr_skid3_chk holds the overflow assertion for this buffer.
// -----------------------------------------------------------------------------
module fifo_vr_skid3
    import fifo_vr_drain_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          valid,
    output skid_cnt_t     count
);
    logic [DW-1:0] mem [SKID_DEPTH];
    skid_cnt_t     head;
    skid_cnt_t     tail;

    // Pointer and occupancy update; push and pop together leave count as is
    always_ff @(posedge clk) begin
        if (srst) begin
            head  <= 2'd0;
            tail  <= 2'd0;
            count <= 2'd0;
        end else begin
            if (push) begin
                tail <= ptr_inc(tail);
            end else begin
                tail <= tail;
            end
            if (pop) begin
                head <= ptr_inc(head);
            end else begin
                head <= head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Word storage, deliberately without reset
    always_ff @(posedge clk) begin
        if (push && !srst) begin
            mem[tail] <= push_data;
        end
    end

    assign valid     = (count != 2'd0);
    assign head_data = mem[head];

    fifo_vr_skid3_chk u_chk (
        .clk   (clk),
        .srst  (srst),
        .push  (push),
        .count (count)
    );
endmodule

// -----------------------------------------------------------------------------
// fifo_vr_skid3_chk
// Property checker for fifo_vr_skid3: a push into a full buffer is a bug in
// the read-issue logic upstream.
// -----------------------------------------------------------------------------
module fifo_vr_skid3_chk
    import fifo_vr_drain_pkg::*;
(
    input logic      clk,
    input logic      srst,
    input logic      push,
    input skid_cnt_t count
);
    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (srst) !(push && (count == 2'd3))
    );
endmodule

// File: rtl/fifo_vr_drain.sv
// -----------------------------------------------------------------------------
// fifo_vr_drain
// Drains the read side of a synchronous FIFO (registered rdata, latency 1)
// into a valid/ready stream through a 3-entry skid buffer, so the FIFO read
// never depends combinationally on downstream ready.
//   DW, DL   : data width and FIFO depth log2 (must match the FIFO interface)
//   clk      : clock
//   rst      : synchronous active-high reset, overrides flush
//   flush    : synchronous drain flush; clears the FIFO and the buffer
//   fifo     : common_sync_fifo_if master (read side only, write tied off)
//   out      : vr_if master, one valid, one ready, one DW-bit lane
//   xfer_cnt : handshake counter, present only with FIFO_VR_DRAIN_STAT_EN
// -----------------------------------------------------------------------------
module fifo_vr_drain
    import fifo_vr_drain_pkg::*;
#(
    parameter int DW = 32,
    parameter int DL = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    common_sync_fifo_if.master fifo,
    vr_if.master               out
`ifdef FIFO_VR_DRAIN_STAT_EN
    ,
    output logic [31:0]        xfer_cnt
`endif
);
    skid_cnt_t     count;
    logic          inflight;
    logic          read_s;
    logic          push_s;
    logic          pop_s;
    logic          skid_clear_s;
    logic          skid_valid_s;
    logic [DW-1:0] head_data_s;
    logic [2:0]    committed_s;

    if (DL < 1) begin : g_bad_dl
        $error("fifo_vr_drain: DL must be at least 1");
    end

    // Words already owned by the buffer, counting the one returning next cycle
    always_comb begin
        committed_s = {1'b0, count} + {2'b00, inflight};
    end

    // Read issue from registered occupancy only, so it can never overfill
    always_comb begin
        if (!rst && !flush && fifo.s.nempty && (committed_s < 3'(SKID_DEPTH))) begin
            read_s = 1'b1;
        end else begin
            read_s = 1'b0;
        end
    end

    // In-flight flag: rdata for a read issued now arrives next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else if (flush) begin
            inflight <= 1'b0;
        end else begin
            inflight <= read_s;
        end
    end

    // A flush in the return cycle discards the word instead of storing it
    assign push_s       = inflight & ~flush;
    assign pop_s        = skid_valid_s & out.ready[0];
    assign skid_clear_s = rst | flush;

    fifo_vr_skid3 #(
        .DW (DW)
    ) u_skid (
        .clk       (clk),
        .srst      (skid_clear_s),
        .push      (push_s),
        .push_data (fifo.s.rdata),
        .pop       (pop_s),
        .head_data (head_data_s),
        .valid     (skid_valid_s),
        .count     (count)
    );

    assign out.valid    = skid_valid_s;
    assign out.data[0]  = head_data_s;

    assign fifo.m.read  = read_s;
    assign fifo.m.clr   = flush & ~rst;
    assign fifo.m.write = 1'b0;
    assign fifo.m.wdata = {DW{1'b0}};

`ifdef FIFO_VR_DRAIN_STAT_EN
    // Handshake counter; survives flush, wraps at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= 32'd0;
        end else if (pop_s) begin
            xfer_cnt <= xfer_cnt + 32'd1;
        end else begin
            xfer_cnt <= xfer_cnt;
        end
    end
`endif

endmodule
